// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default link timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_PARITY = 3'd5
  } uart_state_e;

  // 50 MHz system clock at 115200 baud, 8N1 framing.
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer with falling-edge detect; all flops reset to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic iRx,
  output logic rxs,
  output logic fall
);

  logic meta_q;
  logic rxs_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= iRx;
      rxs_q  <= meta_q;
      prev_q <= rxs_q;
    end
  end

  assign rxs  = rxs_q;
  // Edge rather than level, so a held-low line (break) cannot retrigger.
  assign fall = prev_q & ~rxs_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive engine: centre-sampled, LSB-first deserializer with done strobe and frame error.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for a falling edge on the synchronized line
// ST_START  | counting to the start-bit centre, rejecting glitches
// ST_DATA   | sampling data bits at each bit centre
// ST_PARITY | sampling the parity bit (parity build only)
// ST_STOP   | sampling the stop bit
// ST_DONE   | one-cycle strobe with updated data/error outputs
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iRx,
  output logic [DATA_BITS-1:0] oData,
  output logic                 oRxDone,
  output logic                 oFrameErr,
  output logic                 oBusy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 oParityErr
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxs;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .iRx  (iRx),
    .rxs  (rxs),
    .fall (fall)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ferr_d   = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rxs ^ 1'(PARITY_ODD);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          // Outputs load on the way into DONE so they are valid with the strobe.
          cnt_d   = '0;
          data_d  = shift_q;
          ferr_d  = ~rxs;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad_q;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign oData     = data_q;
  assign oFrameErr = ferr_q;
  assign oRxDone   = (state_q == ST_DONE);
  assign oBusy     = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign oParityErr = perr_q;
`endif

endmodule
